mem_arbiter2: RTL and testbench
===============================

Name: mem_arbiter2

Overview:
- Two-master, one-slave arbiter for the picorv32 native memory interface.
- Sits directly upstream of the memory controller. Merges two requesters onto the single memory port: CPU core and a second bus master (DMA/video/debug loader).
- Round-robin fairness; the grant is held for a whole transaction.
- Bounded wait: a stalled slave causes a timeout response rather than a hang.

Parameters:
- TIMEOUT, 255: max cycles a granted transaction waits for s_mem_ready before a forced completion; 8-bit counter; 0 disables the timeout.
- TIMEOUT_DATA, 32'h0000_0000: rdata returned to the master on a timed-out transaction.

Ports:
- clk  input  1  system clock; all state on rising edge
- reset  input  1  synchronous, active-high reset
- m0_mem_valid  input  1  master 0 request
- m0_mem_ready  output  1  master 0 transaction complete
- m0_mem_instr  input  1  master 0 instruction fetch flag
- m0_mem_wstrb  input  4  master 0 byte write strobes (0 = read)
- m0_mem_wdata  input  32  master 0 write data
- m0_mem_addr  input  32  master 0 byte address
- m0_mem_rdata  output  32  master 0 read data
- m1_mem_valid, m1_mem_ready, m1_mem_instr, m1_mem_wstrb, m1_mem_wdata, m1_mem_addr, m1_mem_rdata: same as m0, for master 1
- s_mem_valid  output  1  request to memory controller
- s_mem_ready  input  1  memory controller completion; may be combinational from s_mem_valid
- s_mem_instr  output  1  forwarded instr flag
- s_mem_wstrb  output  4  forwarded strobes
- s_mem_wdata  output  32  forwarded write data
- s_mem_addr  output  32  forwarded address
- s_mem_rdata  input  32  memory read data
- timeout_err  output  1  one-cycle pulse when a transaction is force-completed

Behaviour:
- States: IDLE, BUSY0, BUSY1. Registers: state, last_grant (1 bit), wait_cnt (8 bit).
- Reset: state=IDLE, last_grant=1 (m0 wins first tie), wait_cnt=0.
- Outputs during and after reset: s_mem_valid=0, m0/m1_mem_ready=0, timeout_err=0.
- IDLE arbitration:
  - Only mX_valid set: go to BUSYX.
  - Both valid: grant the master not equal to last_grant.
  - Registered decision, so the first s_mem_valid appears one cycle after mX_valid rises (1-cycle arbitration latency).
- BUSYX outputs:
  - s_mem_valid = mX_mem_valid.
  - s_mem_addr/wdata/wstrb/instr = master X's signals, combinational mux.
  - mX_mem_rdata = s_mem_rdata.
  - mX_mem_ready = s_mem_ready.
  - The non-granted master sees ready=0; its rdata is don't-care, driven 0.
- In IDLE: s_mem_valid=0; s_mem_wstrb=0; s_mem_addr/wdata/instr don't-care, driven from m0.
- Completion in BUSYX when s_mem_ready=1: next state IDLE, last_grant=X, wait_cnt=0.
- Back-to-back: the minimum gap between transactions is one IDLE cycle. With both masters requesting continuously, grants alternate m0,m1,m0,...
- Timeout (TIMEOUT≠0):
  - wait_cnt increments each BUSY cycle without s_mem_ready.
  - When wait_cnt==TIMEOUT and s_mem_ready=0: assert mX_mem_ready=1 and mX_mem_rdata=TIMEOUT_DATA, and pulse timeout_err for one cycle.
  - Next state IDLE, last_grant=X. s_mem_valid stays asserted in that cycle.
  - If s_mem_ready and the timeout coincide, s_mem_ready wins: normal data, no error.
- Master drops valid while BUSY (protocol violation): s_mem_valid follows it to 0 in the same cycle; next state IDLE; no ready issued; last_grant=X.
- Reset asserted mid-transaction: the next cycle is IDLE with all outputs at reset values; an in-flight write may or may not have committed in the slave.
- Master ready is never asserted in IDLE, and never to both masters in one cycle.
- No address decode: every request goes to the slave.

Decomposition:
- Shared package xoro_bus_pkg:
  - state encoding constants (ST_IDLE=2'd0, ST_BUSY0=2'd1, ST_BUSY1=2'd2)
  - bus width constants (ADDR_W=32, DATA_W=32, STRB_W=4)
- No sub-module needed. The optional timeout counter may be split out as bus_timeout_cnt (load/clear/terminal-count outputs); the arbiter FSM stays in mem_arbiter2.

Test Plan:
- Single m0 read:
  - Stimulus: m0_valid=1, addr=0x100, wstrb=0; memory model with combinational ready and rdata=0xCAFEBABE.
  - Required: s_mem_valid rises at cycle+1; m0_ready=1 with rdata=0xCAFEBABE at cycle+1; IDLE at cycle+2.
- Simultaneous request after reset: both valid at the same edge; m0 granted first. m0 write (wstrb=4'hF, wdata=0x12345678) completes. Then m1 read of the same address returns 0x12345678.
- Continuous contention: both masters re-request immediately for 8 transactions; grant sequence is m0,m1,m0,m1,m0,m1,m0,m1, with exactly one IDLE cycle between each.
- Timeout:
  - Stimulus: TIMEOUT=4, slave ready held 0, m1 read.
  - Required: m1_ready=1, m1_rdata=TIMEOUT_DATA and timeout_err=1 on the 5th BUSY cycle (wait_cnt==4); timeout_err low all other cycles; the next request is m0-preferred.
- Slave wait states: ready delayed 3 cycles; master ready only on the 3rd BUSY cycle; addr/wdata stable on the s_ port throughout; timeout_err=0.
- Reset mid-BUSY1: assert reset for 1 cycle. Required next cycle: s_mem_valid=0, both readys 0, state IDLE; then simultaneous requests grant m0 first.

Source files
------------

// File: rtl/xoro_bus_pkg.sv
// Shared definitions for the picorv32 native memory bus blocks:
// bus widths and the arbiter state encoding.
package xoro_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  // Arbiter FSM states; BUSYx means master x owns the slave port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2
  } state_t;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Wait-cycle counter for a granted bus transaction. Counts busy cycles
// that have not completed and flags when the limit is reached.
// A TIMEOUT of 0 disables the terminal count entirely.
module bus_timeout_cnt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_tc
);

  localparam logic [7:0] LP_LIMIT = 8'(TIMEOUT);

  logic [7:0] r_count;

  // Wait counter: cleared between transactions, advanced per stalled cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      r_count <= 8'd0;
    end else if (i_clear) begin
      r_count <= 8'd0;
    end else if (i_inc) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_tc = (LP_LIMIT != 8'd0) && (r_count == LP_LIMIT);

endmodule

// File: rtl/mem_arbiter2.sv
// Two-master round-robin arbiter onto one picorv32 native memory port.
// The grant is registered in IDLE and held for a whole transaction; a
// stalled slave is force-completed after TIMEOUT waiting cycles.
module mem_arbiter2
  import xoro_bus_pkg::*;
#(
  parameter int unsigned        TIMEOUT      = 255,
  parameter logic [DATA_W-1:0]  TIMEOUT_DATA = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  // master 0 (CPU core)
  input  logic              m0_mem_valid,
  output logic              m0_mem_ready,
  input  logic              m0_mem_instr,
  input  logic [STRB_W-1:0] m0_mem_wstrb,
  input  logic [DATA_W-1:0] m0_mem_wdata,
  input  logic [ADDR_W-1:0] m0_mem_addr,
  output logic [DATA_W-1:0] m0_mem_rdata,
  // master 1 (second bus master)
  input  logic              m1_mem_valid,
  output logic              m1_mem_ready,
  input  logic              m1_mem_instr,
  input  logic [STRB_W-1:0] m1_mem_wstrb,
  input  logic [DATA_W-1:0] m1_mem_wdata,
  input  logic [ADDR_W-1:0] m1_mem_addr,
  output logic [DATA_W-1:0] m1_mem_rdata,
  // slave (memory controller)
  output logic              s_mem_valid,
  input  logic              s_mem_ready,
  output logic              s_mem_instr,
  output logic [STRB_W-1:0] s_mem_wstrb,
  output logic [DATA_W-1:0] s_mem_wdata,
  output logic [ADDR_W-1:0] s_mem_addr,
  input  logic [DATA_W-1:0] s_mem_rdata,
  output logic              timeout_err
);

  state_t r_state;
  state_t w_next_state;
  logic   r_last_grant;
  logic   w_next_last_grant;

  logic   w_busy;
  logic   w_sel1;
  logic   w_gnt_valid;
  logic   w_tc;
  logic   w_done;
  logic   w_forced;
  logic   w_exit;
  logic   w_cnt_clear;
  logic   w_cnt_inc;
  logic   [DATA_W-1:0] w_ret_data;

  assign w_busy      = (r_state != ST_IDLE);
  assign w_sel1      = (r_state == ST_BUSY1);
  assign w_gnt_valid = w_sel1 ? m1_mem_valid : m0_mem_valid;

  // Normal completion beats a coincident timeout.
  assign w_done   = w_busy & w_gnt_valid & s_mem_ready;
  assign w_forced = w_busy & w_gnt_valid & ~s_mem_ready & w_tc;
  // Leaving BUSY: completion, forced completion, or the master gave up.
  assign w_exit   = w_busy & (~w_gnt_valid | s_mem_ready | w_tc);

  assign w_cnt_clear = ~w_busy | w_exit;
  assign w_cnt_inc   = w_busy & ~w_exit;

  assign w_ret_data  = w_forced ? TIMEOUT_DATA : s_mem_rdata;

  bus_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_cnt_clear),
    .i_inc   (w_cnt_inc),
    .o_tc    (w_tc)
  );

  // State register: current owner and round-robin history.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;  // m0 wins the first tie
    end else begin
      r_state      <= w_next_state;
      r_last_grant <= w_next_last_grant;
    end
  end

  // Next-state logic: arbitrate in IDLE, return to IDLE when BUSY ends.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_next_state      = r_state;
    w_next_last_grant = r_last_grant;
    case (r_state)
      ST_IDLE: begin
        if (m0_mem_valid && m1_mem_valid) begin
          w_next_state = r_last_grant ? ST_BUSY0 : ST_BUSY1;
        end else if (m0_mem_valid) begin
          w_next_state = ST_BUSY0;
        end else if (m1_mem_valid) begin
          w_next_state = ST_BUSY1;
        end
      end
      ST_BUSY0, ST_BUSY1: begin
        if (w_exit) begin
          w_next_state      = ST_IDLE;
          w_next_last_grant = w_sel1;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Output logic: route the owning master to the slave and back.
  always_comb begin
    s_mem_valid  = 1'b0;
    s_mem_instr  = m0_mem_instr;
    s_mem_wstrb  = '0;
    s_mem_wdata  = m0_mem_wdata;
    s_mem_addr   = m0_mem_addr;
    m0_mem_ready = 1'b0;
    m0_mem_rdata = '0;
    m1_mem_ready = 1'b0;
    m1_mem_rdata = '0;
    timeout_err  = 1'b0;
    case (r_state)
      ST_BUSY0: begin
        s_mem_valid  = m0_mem_valid;
        s_mem_wstrb  = m0_mem_wstrb;
        m0_mem_ready = w_done | w_forced;
        m0_mem_rdata = w_ret_data;
        timeout_err  = w_forced;
      end
      ST_BUSY1: begin
        s_mem_valid  = m1_mem_valid;
        s_mem_instr  = m1_mem_instr;
        s_mem_wstrb  = m1_mem_wstrb;
        s_mem_wdata  = m1_mem_wdata;
        s_mem_addr   = m1_mem_addr;
        m1_mem_ready = w_done | w_forced;
        m1_mem_rdata = w_ret_data;
        timeout_err  = w_forced;
      end
      default: begin
      end
    endcase
    // Handshake outputs are held quiet for the whole reset cycle, even
    // before the state register has been cleared by the edge.
    if (reset) begin
      s_mem_valid  = 1'b0;
      m0_mem_ready = 1'b0;
      m1_mem_ready = 1'b0;
      timeout_err  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter2.sv
// Directed bench for mem_arbiter2 with a small word memory model whose
// ready is combinational, stalled, or delayed by two wait cycles.
module tb_mem_arbiter2;
  import xoro_bus_pkg::*;

  localparam int unsigned TB_TIMEOUT = 4;
  localparam logic [31:0] TB_TO_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {MD_COMB, MD_STALL, MD_DELAY} mode_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_mem_valid, m0_mem_ready, m0_mem_instr;
  logic [3:0]  m0_mem_wstrb;
  logic [31:0] m0_mem_wdata, m0_mem_addr, m0_mem_rdata;
  logic        m1_mem_valid, m1_mem_ready, m1_mem_instr;
  logic [3:0]  m1_mem_wstrb;
  logic [31:0] m1_mem_wdata, m1_mem_addr, m1_mem_rdata;
  logic        s_mem_valid, s_mem_ready, s_mem_instr;
  logic [3:0]  s_mem_wstrb;
  logic [31:0] s_mem_wdata, s_mem_addr, s_mem_rdata;
  logic        timeout_err;

  mode_t       mode;
  logic [31:0] mem [0:255];
  logic [1:0]  tb_wait;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter2 #(
    .TIMEOUT      (TB_TIMEOUT),
    .TIMEOUT_DATA (TB_TO_DATA)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .m0_mem_valid (m0_mem_valid),
    .m0_mem_ready (m0_mem_ready),
    .m0_mem_instr (m0_mem_instr),
    .m0_mem_wstrb (m0_mem_wstrb),
    .m0_mem_wdata (m0_mem_wdata),
    .m0_mem_addr  (m0_mem_addr),
    .m0_mem_rdata (m0_mem_rdata),
    .m1_mem_valid (m1_mem_valid),
    .m1_mem_ready (m1_mem_ready),
    .m1_mem_instr (m1_mem_instr),
    .m1_mem_wstrb (m1_mem_wstrb),
    .m1_mem_wdata (m1_mem_wdata),
    .m1_mem_addr  (m1_mem_addr),
    .m1_mem_rdata (m1_mem_rdata),
    .s_mem_valid  (s_mem_valid),
    .s_mem_ready  (s_mem_ready),
    .s_mem_instr  (s_mem_instr),
    .s_mem_wstrb  (s_mem_wstrb),
    .s_mem_wdata  (s_mem_wdata),
    .s_mem_addr   (s_mem_addr),
    .s_mem_rdata  (s_mem_rdata),
    .timeout_err  (timeout_err)
  );

  // Slave ready behaviour selected by the current test step.
  always_comb begin
    case (mode)
      MD_STALL: s_mem_ready = 1'b0;
      MD_DELAY: s_mem_ready = s_mem_valid && (tb_wait == 2'd2);
      default:  s_mem_ready = s_mem_valid;
    endcase
  end

  assign s_mem_rdata = mem[s_mem_addr[9:2]];

  // Memory contents: preloaded on reset, byte-strobed writes on handshake.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[64] <= 32'hCAFE_BABE;
    end else if (s_mem_valid && s_mem_ready) begin
      for (int b = 0; b < 4; b++)
        if (s_mem_wstrb[b]) mem[s_mem_addr[9:2]][8*b +: 8] <= s_mem_wdata[8*b +: 8];
    end
  end

  // Wait-state counter for the delayed-ready mode.
  always @(posedge clk) begin
    if (reset || !s_mem_valid || s_mem_ready) tb_wait <= 2'd0;
    else tb_wait <= tb_wait + 2'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_st(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_masters();
    m0_mem_valid = 1'b0; m0_mem_instr = 1'b0; m0_mem_wstrb = 4'h0;
    m0_mem_wdata = 32'h0; m0_mem_addr = 32'h0;
    m1_mem_valid = 1'b0; m1_mem_instr = 1'b0; m1_mem_wstrb = 4'h0;
    m1_mem_wdata = 32'h0; m1_mem_addr = 32'h0;
  endtask

  // Two-cycle reset; returns at a negedge with reset released, state IDLE.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_masters();
    mode = MD_COMB;
    @(negedge clk);
    #1;
    check_bit("rst_s_valid", s_mem_valid, 1'b0);
    check_bit("rst_m0_ready", m0_mem_ready, 1'b0);
    check_bit("rst_m1_ready", m1_mem_ready, 1'b0);
    check_bit("rst_timeout_err", timeout_err, 1'b0);
    check_st("rst_state", dut.r_state, ST_IDLE);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    mode  = MD_COMB;
    idle_masters();

    // Single m0 read with combinational ready.
    do_reset();
    m0_mem_valid = 1'b1; m0_mem_addr = 32'h100; m0_mem_wstrb = 4'h0;
    #1;
    check_bit("t1_arb_latency", s_mem_valid, 1'b0);
    @(negedge clk); #1;
    check_bit("t1_s_valid", s_mem_valid, 1'b1);
    check("t1_s_addr", s_mem_addr, 32'h100);
    check_bit("t1_m0_ready", m0_mem_ready, 1'b1);
    check("t1_m0_rdata", m0_mem_rdata, 32'hCAFE_BABE);
    check_bit("t1_m1_ready", m1_mem_ready, 1'b0);
    @(negedge clk);
    m0_mem_valid = 1'b0;
    #1;
    check_st("t1_back_idle", dut.r_state, ST_IDLE);
    check_bit("t1_idle_m0_ready", m0_mem_ready, 1'b0);

    // Simultaneous request after reset: m0 write, then m1 reads it back.
    do_reset();
    m0_mem_valid = 1'b1; m0_mem_addr = 32'h200; m0_mem_wstrb = 4'hF; m0_mem_wdata = 32'h1234_5678;
    m1_mem_valid = 1'b1; m1_mem_addr = 32'h200; m1_mem_wstrb = 4'h0;
    @(negedge clk); #1;
    check_bit("t2_m0_ready", m0_mem_ready, 1'b1);
    check_bit("t2_m1_not_ready", m1_mem_ready, 1'b0);
    check("t2_s_wstrb", {28'h0, s_mem_wstrb}, 32'hF);
    check("t2_s_wdata", s_mem_wdata, 32'h1234_5678);
    @(negedge clk);
    m0_mem_valid = 1'b0; m0_mem_wstrb = 4'h0;
    #1;
    check_bit("t2_gap_s_valid", s_mem_valid, 1'b0);
    @(negedge clk); #1;
    check_bit("t2_m1_ready", m1_mem_ready, 1'b1);
    check("t2_m1_rdata", m1_mem_rdata, 32'h1234_5678);
    check_bit("t2_m0_not_ready", m0_mem_ready, 1'b0);
    @(negedge clk);
    m1_mem_valid = 1'b0;

    // Continuous contention: grants alternate with one IDLE cycle between.
    @(negedge clk);
    m0_mem_valid = 1'b1; m0_mem_addr = 32'h100;
    m1_mem_valid = 1'b1; m1_mem_addr = 32'h200;
    #1;
    check_bit("t3_start_idle", s_mem_valid, 1'b0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); #1;
      if (k % 2 == 0) begin
        check_bit($sformatf("t3_m0_ready_%0d", k), m0_mem_ready, ((k / 2) % 2) == 0);
        check_bit($sformatf("t3_m1_ready_%0d", k), m1_mem_ready, ((k / 2) % 2) == 1);
        check_bit($sformatf("t3_s_valid_%0d", k), s_mem_valid, 1'b1);
      end else begin
        check_st($sformatf("t3_idle_%0d", k), dut.r_state, ST_IDLE);
        check_bit($sformatf("t3_gap_ready_%0d", k), m0_mem_ready | m1_mem_ready, 1'b0);
      end
    end
    m0_mem_valid = 1'b0;
    m1_mem_valid = 1'b0;

    // Timeout: stalled slave, m1 read force-completed on 5th BUSY cycle.
    @(negedge clk);
    mode = MD_STALL;
    m1_mem_valid = 1'b1; m1_mem_addr = 32'h100;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); #1;
      check_bit($sformatf("t4_m1_ready_%0d", i), m1_mem_ready, i == 5);
      check_bit($sformatf("t4_err_%0d", i), timeout_err, i == 5);
      check_bit($sformatf("t4_s_valid_%0d", i), s_mem_valid, 1'b1);
      if (i == 5) check("t4_m1_rdata", m1_mem_rdata, TB_TO_DATA);
    end
    @(negedge clk);
    m1_mem_valid = 1'b0;
    #1;
    check_bit("t4_err_after", timeout_err, 1'b0);
    check_st("t4_idle_after", dut.r_state, ST_IDLE);
    mode = MD_COMB;
    m0_mem_valid = 1'b1; m0_mem_addr = 32'h100;
    m1_mem_valid = 1'b1; m1_mem_addr = 32'h200;
    @(negedge clk); #1;
    check_bit("t4_next_m0", m0_mem_ready, 1'b1);
    check_bit("t4_next_not_m1", m1_mem_ready, 1'b0);

    // Slave wait states: ready only on the 3rd BUSY cycle, bus held stable.
    @(negedge clk);
    m1_mem_valid = 1'b0;
    mode = MD_DELAY;
    m0_mem_addr = 32'h300; m0_mem_wdata = 32'hA5A5_5A5A; m0_mem_wstrb = 4'hF;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); #1;
      check_bit($sformatf("t5_m0_ready_%0d", i), m0_mem_ready, i == 3);
      check($sformatf("t5_s_addr_%0d", i), s_mem_addr, 32'h300);
      check($sformatf("t5_s_wdata_%0d", i), s_mem_wdata, 32'hA5A5_5A5A);
      check_bit($sformatf("t5_err_%0d", i), timeout_err, 1'b0);
    end
    @(negedge clk);
    m0_mem_valid = 1'b0; m0_mem_wstrb = 4'h0;
    mode = MD_COMB;
    m1_mem_valid = 1'b1; m1_mem_addr = 32'h300;
    #1;
    check_st("t5_idle", dut.r_state, ST_IDLE);
    @(negedge clk); #1;
    check_bit("t5_rb_ready", m1_mem_ready, 1'b1);
    check("t5_rb_rdata", m1_mem_rdata, 32'hA5A5_5A5A);

    // Reset during BUSY1, then a tie goes to m0.
    @(negedge clk);
    mode = MD_STALL;
    @(negedge clk); #1;
    check_st("t6_busy1", dut.r_state, ST_BUSY1);
    check_bit("t6_busy_s_valid", s_mem_valid, 1'b1);
    reset = 1'b1;
    #1;
    check_bit("t6_during_rst_s_valid", s_mem_valid, 1'b0);
    check_bit("t6_during_rst_m1_ready", m1_mem_ready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    mode = MD_COMB;
    m0_mem_valid = 1'b1; m0_mem_addr = 32'h100;
    #1;
    check_st("t6_after_rst_idle", dut.r_state, ST_IDLE);
    check_bit("t6_after_rst_s_valid", s_mem_valid, 1'b0);
    check_bit("t6_after_rst_ready", m0_mem_ready | m1_mem_ready, 1'b0);
    @(negedge clk); #1;
    check_bit("t6_tie_m0", m0_mem_ready, 1'b1);
    check_bit("t6_tie_not_m1", m1_mem_ready, 1'b0);
    check("t6_tie_rdata", m0_mem_rdata, 32'hCAFE_BABE);
    @(negedge clk);
    idle_masters();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
